// File: rtl/sdram_port_arbiter.sv
// N-channel round-robin front end sharing one sdram_mac register interface.
// Optional idle-ownership timeout enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int N_CH    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_CH-1:0]           C_REQ,
  output logic [N_CH-1:0]           C_GNT,
  input  logic [N_CH-1:0]           C_WE,
  input  logic [N_CH-1:0]           C_WE_LEN,
  input  logic [N_CH-1:0]           C_WE_A,
  input  logic [N_CH*AW-1:0]        C_ADDR,
  input  logic [N_CH*DW-1:0]        C_WD,
  output logic [DW-1:0]             C_RD,
  output logic [N_CH-1:0]           C_BUSY,
  output logic [AW-1:0]             M_ADDR,
  output logic [DW-1:0]             M_WD,
  output logic                      M_WE,
  output logic                      M_WE_LEN,
  output logic                      M_WE_A,
  input  logic [DW-1:0]             M_RD,
  input  logic                      M_BUSY,
  output logic [$clog2(N_CH)-1:0]   OWNER,
  output logic [N_CH-1:0]           ERR_TO
);

  localparam int OW = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 8 || TIMEOUT < 1) begin : g_param_check
    $error("sdram_port_arbiter: N_CH must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_WAIT, S_RELEASE} state_t;

  state_t          state;
  logic [N_CH-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            wait_first;

  logic [OW-1:0]   sel;
  logic [OW-1:0]   cand;
  logic            sel_vld;

  logic            own_req, own_we, own_we_len, own_we_a;
  logic            fwd, any_fwd, holds_mac, to_fire;

  // Scan downward so the nearest requester after the last owner wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = OW'((int'(owner) + k) % N_CH);
      if (C_REQ[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign own_req    = C_REQ[owner];
  assign own_we     = C_WE[owner];
  assign own_we_len = C_WE_LEN[owner];
  assign own_we_a   = C_WE_A[owner];

  // Strobes pass straight through only while owning and the MAC is free.
  assign fwd       = (state == S_OWN) && !M_BUSY && !RESET;
  assign any_fwd   = fwd && (own_we || own_we_len || own_we_a);
  assign holds_mac = (state == S_OWN) || (state == S_WAIT);

  assign M_WE     = fwd && own_we;
  assign M_WE_LEN = fwd && own_we_len;
  assign M_WE_A   = fwd && own_we_a;
  assign M_ADDR   = holds_mac ? C_ADDR[int'(owner)*AW +: AW] : '0;
  assign M_WD     = holds_mac ? C_WD[int'(owner)*DW +: DW] : '0;

  assign C_RD   = M_RD;
  assign C_GNT  = gnt;
  assign OWNER  = owner;
  assign C_BUSY = ~gnt | {N_CH{(state == S_WAIT) || M_BUSY}};

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   idle_cnt;
  logic [N_CH-1:0] err_to;

  assign to_fire = (state == S_OWN) && own_req && !any_fwd &&
                   (idle_cnt == CW'(TIMEOUT - 1));
  assign ERR_TO  = err_to;

  // Counter sits at zero outside OWN, so every entry to OWN starts fresh.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idle_cnt <= '0;
      err_to   <= '0;
    end else begin
      if (state != S_OWN || any_fwd)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      if (to_fire)
        err_to[owner] <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign ERR_TO  = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      gnt        <= '0;
      owner      <= OW'(N_CH - 1);
      wait_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            gnt        <= '0;
            gnt[sel]   <= 1'b1;
            owner      <= sel;
            state      <= S_OWN;
          end
        end
        S_OWN: begin
          if (fwd && own_we_a) begin
            state      <= S_WAIT;
            wait_first <= 1'b1;
          end else if (!own_req || to_fire) begin
            state <= S_RELEASE;
            gnt   <= '0;
          end
        end
        S_WAIT: begin
          // M_BUSY only rises the cycle after the start strobe.
          wait_first <= 1'b0;
          if (!wait_first && !M_BUSY) begin
            if (own_req) begin
              state <= S_OWN;
            end else begin
              state <= S_RELEASE;
              gnt   <= '0;
            end
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Parametrised N-channel front end for the SDRAM MAC register interface (ADDR/WD/WE/WE_LEN/WE_A/RD/BUSY).
- Lets several hosts (JTAG bridge, BIST, video fetch, ...) share one sdram_mac. Sits between the clients and sdram_mac in the toplevel.
- Arbitration is round-robin at transaction granularity. The owner keeps the MAC across multiple set-up writes and starts until it drops its request.

Parameters:
- N_CH, 4: number of client channels, 2..8.
- AW, 8: MAC register address width.
- DW, 32: MAC data width.
- TIMEOUT, 1024: idle-ownership limit in cycles. Used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- C_REQ  in  N_CH  per-client ownership request (level).
- C_GNT  out  N_CH  per-client grant, one-hot or zero.
- C_WE  in  N_CH  per-client data-register write strobe.
- C_WE_LEN  in  N_CH  per-client length write strobe.
- C_WE_A  in  N_CH  per-client address write / start strobe.
- C_ADDR  in  N_CH*AW  per-client register address, packed (ch i at [i*AW +: AW]).
- C_WD  in  N_CH*DW  per-client write data, packed.
- C_RD  out  DW  MAC read data, broadcast to all clients.
- C_BUSY  out  N_CH  per-client busy.
- M_ADDR  out  AW  to MAC.
- M_WD  out  DW  to MAC.
- M_WE  out  1  to MAC.
- M_WE_LEN  out  1  to MAC.
- M_WE_A  out  1  to MAC.
- M_RD  in  DW  from MAC.
- M_BUSY  in  1  from MAC; rises the cycle after M_WE_A.
- OWNER  out  $clog2(N_CH)  index of last/current owner (LED debug).
- ERR_TO  out  N_CH  sticky timeout flags.

Behaviour:
- Reset (sync, active-high, mid-operation allowed) sets:
  - state IDLE, C_GNT=0, OWNER=N_CH-1 (channel 0 wins first), ERR_TO=0.
  - M_WE/M_WE_LEN/M_WE_A are 0 during the RESET cycle and the cycle after.
  - No pending MAC transfer is tracked after reset.
- States: IDLE, OWN, WAIT, RELEASE.
- IDLE:
  - If any C_REQ is set, select the first requesting channel after OWNER, wrapping N_CH-1→0.
  - Next cycle: C_GNT[sel]=1, OWNER=sel, go to OWN. REQ-to-GNT latency is exactly 1 cycle.
  - If no C_REQ is set, stay in IDLE.
- OWN:
  - Owner's strobes, ADDR and WD are forwarded combinationally (zero latency) to M_*.
  - Forwarding is gated by ~M_BUSY. All non-owner strobes are ignored.
  - Owner C_WE_A forwarded → go to WAIT.
  - Owner C_REQ low → go to RELEASE. If C_REQ low and a strobe occur in the same cycle, the strobe is forwarded, then the block releases; a WE_A in that cycle goes to WAIT first.
- WAIT:
  - All strobes are blocked.
  - The first cycle in WAIT is unconditional; after it, remain in WAIT while M_BUSY=1.
  - On M_BUSY=0: go to OWN if owner C_REQ=1, else to RELEASE.
  - Owner dropping C_REQ during WAIT never aborts the MAC transfer.
- RELEASE: C_GNT=0 for one cycle, then IDLE. A channel with REQ still high must wait its round-robin turn.
- C_BUSY[i]:
  - Non-granted channel: 1.
  - Granted channel: 1 in WAIT or when M_BUSY=1; 0 in OWN with M_BUSY=0.
- M_ADDR/M_WD are driven with the owner's values in OWN/WAIT and are 0 otherwise.
- C_RD = M_RD always. Clients qualify it with C_GNT.
- Only one channel requesting: it is re-granted after IDLE. Minimum gap between grants is 2 cycles (RELEASE + IDLE).

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- With the macro:
  - An idle counter resets on entry to OWN and on every forwarded strobe, and counts cycles in OWN otherwise.
  - When the counter reaches TIMEOUT, force RELEASE and set sticky ERR_TO[owner]. The flag is cleared only by RESET.
  - The counter does not run in WAIT.
- Without the macro: no counter, ownership is unbounded, ERR_TO tied to 0.

Test Plan:
- Reset, then C_REQ=4'b0110 → C_GNT=4'b0010 one cycle later, OWNER=1. Drop REQ1 → GNT=0 for ≥1 cycle, then GNT=4'b0100.
- Ch0 granted; issues WE_LEN(WD=16), WE(ADDR=3,WD=0xDEADBEEF), WE_A(WD=0x100) → each appears on M_* in the same cycle. Ch2 strobes are never seen on M_*. WAIT holds until M_BUSY falls; C_BUSY[0]=1 throughout.
- All four request continuously, each releases after one WE_A → grant order 0,1,2,3,0.
- Owner drops C_REQ during WAIT while M_BUSY=1 for 20 cycles → no strobes forwarded, GNT held until M_BUSY=0, then RELEASE.
- RESET asserted in WAIT → next cycle C_GNT=0, M_WE*=0, state IDLE. After reset, ch0 wins over ch3 when both request.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT=8: ch1 granted, no strobes → GNT1 drops after 8 cycles, ERR_TO=4'b0010 until RESET. Without the macro, GNT1 is held for 100 cycles and ERR_TO=0.
